bus_interconnect_nxm: RTL

Parametrised shared-bus interconnect connecting NUM_MASTERS requesters (CPU cores) to NUM_SLAVES targets (D-cache, UART, timer, future peripherals). Successor to the fixed 2-master/3-slave interconnect:

- fair round-robin arbitration;
- parameter-driven base/mask address decode;
- decode-error response for unmapped addresses;
- per-transaction timeout so a hung slave cannot lock the bus.

Sits in chip_top between core bus ports and slave blocks.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_interconnect_nxm_rr_arbiter.sv | 32 +++
 rtl/bus_interconnect_nxm.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the N-master / M-slave shared-bus interconnect.
// Holds the transaction FSM encoding, default error read data and index-width helper.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_ERROR_RDATA = 32'hDEAD_BEEF;

    // Width of an index into n items; never zero so single-port builds still elaborate.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_interconnect_nxm_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, cyclically.
// Zero latency; the caller decides when the grant is taken, so no backpressure here.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_vld
);

    int w_j;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_j       = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!o_gnt_vld && i_req[w_j]) begin
                o_gnt[w_j] = 1'b1;
                o_gnt_idx  = IW'(w_j);
                o_gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_interconnect_nxm.sv
// Shared-bus interconnect: round-robin arbitration, base/mask decode, decode-error and timeout responses.
// Grant registered one cycle after request; slave s_ready passes straight back, a stuck slave is cut off after TIMEOUT_CYCLES.
module bus_interconnect_nxm
    import bus_pkg::*;
#(
    parameter int                          NUM_MASTERS    = 2,
    parameter int                          NUM_SLAVES     = 3,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE     = {32'h4000_1000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK     = {32'hFFFF_F000, 32'hFFFF_F000, 32'hC000_0000},
    parameter int                          TIMEOUT_CYCLES = 16,
    parameter logic [31:0]                 ERROR_RDATA    = DEFAULT_ERROR_RDATA
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS*32-1:0]   m_addr,
    input  logic [NUM_MASTERS*32-1:0]   m_wdata,
    input  logic [NUM_MASTERS*4-1:0]    m_wstrb,
    input  logic [NUM_MASTERS-1:0]      m_write,
    input  logic [NUM_MASTERS-1:0]      m_enable,
    output logic [NUM_MASTERS*32-1:0]   m_rdata,
    output logic [NUM_MASTERS-1:0]      m_ready,
    output logic [NUM_MASTERS-1:0]      m_error,
    output logic [NUM_SLAVES*32-1:0]    s_addr,
    output logic [NUM_SLAVES*32-1:0]    s_wdata,
    output logic [NUM_SLAVES*4-1:0]     s_wstrb,
    output logic [NUM_SLAVES-1:0]       s_write,
    output logic [NUM_SLAVES-1:0]       s_enable,
    input  logic [NUM_SLAVES*32-1:0]    s_rdata,
    input  logic [NUM_SLAVES-1:0]       s_ready
);

    localparam int MW = idx_w(NUM_MASTERS);
    localparam int SW = idx_w(NUM_SLAVES);
    localparam int CW = idx_w(TIMEOUT_CYCLES);

    state_t          r_state;
    logic [MW-1:0]   r_rr_ptr;
    logic [MW-1:0]   r_grant;
    logic [SW-1:0]   r_sel;
    logic [CW-1:0]   r_cnt;

    logic [NUM_MASTERS-1:0] w_arb_gnt;
    logic [MW-1:0]          w_arb_idx;
    logic                   w_arb_vld;
    logic [31:0]            w_m_addr  [NUM_MASTERS];
    logic [31:0]            w_m_wdata [NUM_MASTERS];
    logic [3:0]             w_m_wstrb [NUM_MASTERS];
    logic [31:0]            w_s_rdata [NUM_SLAVES];
    logic [31:0]            w_req_addr;
    logic [SW-1:0]          w_dec_idx;
    logic                   w_dec_hit;
    logic [MW-1:0]          w_next_ptr;

    always_comb begin
        for (int j = 0; j < NUM_MASTERS; j++) begin
            w_m_addr[j]  = m_addr[j*32 +: 32];
            w_m_wdata[j] = m_wdata[j*32 +: 32];
            w_m_wstrb[j] = m_wstrb[j*4 +: 4];
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_s_rdata[i] = s_rdata[i*32 +: 32];
        end
    end

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (MW)
    ) u_arb (
        .i_req     (m_enable),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_arb_gnt),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_vld (w_arb_vld)
    );

    // Descending scan so the lowest-numbered matching slave is the one left standing.
    always_comb begin
        w_req_addr = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (w_arb_gnt[j]) w_req_addr = w_req_addr | w_m_addr[j];
        end
        w_dec_hit = 1'b0;
        w_dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((w_req_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                w_dec_hit = 1'b1;
                w_dec_idx = SW'(i);
            end
        end
    end

    assign w_next_ptr = (r_grant == MW'(NUM_MASTERS - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_arb_vld) begin
                        r_grant <= w_arb_idx;
                        r_sel   <= w_dec_idx;
                        r_state <= w_dec_hit ? ST_BUSY : ST_ERR;
                    end
                end
                ST_BUSY: begin
                    // An abandoned request still consumes its turn so the pointer keeps moving.
                    if (!m_enable[r_grant] || s_ready[r_sel]) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                        r_cnt    <= '0;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= ST_ERR;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    r_state  <= ST_IDLE;
                    r_rr_ptr <= w_next_ptr;
                    r_cnt    <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        m_rdata  = '0;
        m_ready  = '0;
        m_error  = '0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        s_write  = '0;
        s_enable = '0;
        if (r_state == ST_BUSY) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                s_addr[i*32 +: 32]  = w_m_addr[r_grant];
                s_wdata[i*32 +: 32] = w_m_wdata[r_grant];
                s_wstrb[i*4 +: 4]   = w_m_wstrb[r_grant];
                s_write[i]          = m_write[r_grant];
                s_enable[i]         = (SW'(i) == r_sel) && m_enable[r_grant];
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (MW'(j) == r_grant) begin
                    m_ready[j]          = m_enable[r_grant] & s_ready[r_sel];
                    m_rdata[j*32 +: 32] = w_s_rdata[r_sel];
                end
            end
        end else if (r_state == ST_ERR) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (MW'(j) == r_grant) begin
                    m_ready[j]          = 1'b1;
                    m_error[j]          = 1'b1;
                    m_rdata[j*32 +: 32] = ERROR_RDATA;
                end
            end
        end
    end

endmodule
